// File: rtl/netlist_bist_driver.sv
// BIST driver/observer for a combinational netlist slice: an LFSR drives the stimulus buses,
// a MISR compacts the response bus, and the final signature is compared against a golden value.
module netlist_bist_driver #(
    parameter int                WIDTH     = 41,
    parameter int                PAT_COUNT = 256,
    parameter logic [WIDTH-1:0]  POLY      = WIDTH'(41'h9),
    parameter logic [WIDTH-1:0]  LFSR_SEED = WIDTH'(41'h1),
    parameter logic [WIDTH-1:0]  MISR_SEED = WIDTH'(41'h0),
    localparam int               CW        = $clog2(PAT_COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] expected_sig,
    input  logic [WIDTH-1:0] resp_c,
    output logic [WIDTH-1:0] pat_a,
    output logic [WIDTH-1:0] pat_b,
    output logic [WIDTH-1:0] signature,
    output logic [CW-1:0]    pat_cnt,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    // state   | meaning
    // IDLE    | waiting for start, stimulus forced to zero
    // APPLY   | stimulus driven, slice settling for one full cycle
    // CAPTURE | response folded into MISR, LFSR advanced
    // DONE    | run complete, signature and pass held
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        APPLY   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] misr_q, misr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic [WIDTH-1:0] misr_next;

    function automatic logic [WIDTH-1:0] shift(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], 1'b0} ^ (x[WIDTH-1] ? POLY : '0);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= '0;
            misr_q  <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        misr_d    = misr_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        misr_next = shift(misr_q) ^ resp_c;
        // abort leaves lfsr/misr/pat_cnt untouched so the failing point stays observable
        if (abort) begin
            state_d = IDLE;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = APPLY;
                        lfsr_d  = LFSR_SEED;
                        misr_d  = MISR_SEED;
                        cnt_d   = '0;
                        pass_d  = 1'b0;
                    end
                end
                APPLY: state_d = CAPTURE;
                CAPTURE: begin
                    misr_d = misr_next;
                    lfsr_d = shift(lfsr_q);
                    if (cnt_q != CW'(PAT_COUNT)) cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(PAT_COUNT - 1)) begin
                        state_d = DONE;
                        pass_d  = (misr_next == expected_sig);
                    end else begin
                        state_d = APPLY;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy      = (state_q == APPLY) || (state_q == CAPTURE);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign signature = misr_q;
    assign pat_cnt   = cnt_q;
    assign pat_a     = busy ? lfsr_q : '0;
    assign pat_b     = busy ? {lfsr_q[WIDTH-2:0], lfsr_q[WIDTH-1]} : '0;

endmodule

// File: tb/tb_netlist_bist_driver.sv
// Randomized self-checking bench for netlist_bist_driver against a pattern-level reference model.
module tb_netlist_bist_driver;

    localparam int          W    = 41;
    localparam int          P    = 4;
    localparam int          CW   = $clog2(P + 1);
    localparam logic [W-1:0] POLY = 41'h9;
    localparam logic [W-1:0] SEED = 41'h100_0000_0000;
    localparam logic [W-1:0] MSEED = 41'h0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [W-1:0]  expected_sig;
    logic [W-1:0]  resp_c;
    logic [W-1:0]  pat_a;
    logic [W-1:0]  pat_b;
    logic [W-1:0]  signature;
    logic [CW-1:0] pat_cnt;
    logic          busy;
    logic          done;
    logic          pass;

    int checks   = 0;
    int failures = 0;

    netlist_bist_driver #(
        .WIDTH(W), .PAT_COUNT(P), .POLY(POLY), .LFSR_SEED(SEED), .MISR_SEED(MSEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .expected_sig(expected_sig), .resp_c(resp_c),
        .pat_a(pat_a), .pat_b(pat_b), .signature(signature), .pat_cnt(pat_cnt),
        .busy(busy), .done(done), .pass(pass)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] x);
        logic [W-1:0] y;
        y = x << 1;
        if (x[W-1]) y = y ^ POLY;
        return y;
    endfunction

    function automatic logic [W-1:0] ref_rotl(input logic [W-1:0] x);
        return (x << 1) | (x >> (W - 1));
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    task automatic check_idle(input string tag);
        check_val({tag, "_busy"},  64'(busy),  64'(0));
        check_val({tag, "_done"},  64'(done),  64'(0));
        check_val({tag, "_pass"},  64'(pass),  64'(0));
        check_val({tag, "_pat_a"}, 64'(pat_a), 64'(0));
        check_val({tag, "_pat_b"}, 64'(pat_b), 64'(0));
    endtask

    // One full run from IDLE or DONE; optionally sprinkles start pulses that must be ignored.
    task automatic run_once(input bit good, input bit glitch);
        logic [W-1:0] resp [P];
        logic [W-1:0] lfsr_m, misr_m, sig;
        sig = MSEED;
        for (int i = 0; i < P; i++) begin
            resp[i] = (i == 0 && !glitch) ? 41'h5 : rand_w();
            sig = ref_shift(sig) ^ resp[i];
        end
        expected_sig = good ? sig : sig ^ (41'h1 << $urandom_range(W - 1));
        lfsr_m = SEED;
        misr_m = MSEED;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < P; i++) begin
            check_val("apply_busy",  64'(busy),      64'(1));
            check_val("apply_done",  64'(done),      64'(0));
            check_val("apply_pat_a", 64'(pat_a),     64'(lfsr_m));
            check_val("apply_pat_b", 64'(pat_b),     64'(ref_rotl(lfsr_m)));
            check_val("apply_cnt",   64'(pat_cnt),   64'(i));
            check_val("apply_sig",   64'(signature), 64'(misr_m));
            resp_c = resp[i];
            if (glitch) start = 1'($urandom_range(1));
            @(negedge clk);
            check_val("capt_busy",  64'(busy),    64'(1));
            check_val("capt_pat_a", 64'(pat_a),   64'(lfsr_m));
            check_val("capt_cnt",   64'(pat_cnt), 64'(i));
            if (glitch) start = 1'($urandom_range(1));
            @(negedge clk);
            start  = 1'b0;
            misr_m = ref_shift(misr_m) ^ resp[i];
            lfsr_m = ref_shift(lfsr_m);
        end
        check_val("done_done",  64'(done),      64'(1));
        check_val("done_busy",  64'(busy),      64'(0));
        check_val("done_pass",  64'(pass),      64'(good));
        check_val("done_sig",   64'(signature), 64'(misr_m));
        check_val("done_cnt",   64'(pat_cnt),   64'(P));
        check_val("done_pat_a", 64'(pat_a),     64'(0));
        check_val("done_pat_b", 64'(pat_b),     64'(0));
        resp_c = rand_w();
        @(negedge clk);
        check_val("hold_done", 64'(done),      64'(1));
        check_val("hold_sig",  64'(signature), 64'(misr_m));
        check_val("hold_pass", 64'(pass),      64'(good));
    endtask

    initial begin
        logic [W-1:0] r0, m1;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        expected_sig = '0;
        resp_c = '0;
        @(negedge clk);
        @(negedge clk);
        check_idle("rst");
        check_val("rst_sig", 64'(signature), 64'(0));
        check_val("rst_cnt", 64'(pat_cnt),   64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_rst");

        run_once(1'b1, 1'b0);
        run_once(1'b0, 1'b1);
        run_once(1'b1, 1'b1);

        // abort during the second CAPTURE: counters held, outputs quiet
        r0 = rand_w();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        resp_c = r0;
        @(negedge clk);
        @(negedge clk);
        resp_c = rand_w();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        m1 = ref_shift(MSEED) ^ r0;
        check_idle("abort");
        check_val("abort_cnt", 64'(pat_cnt),   64'(1));
        check_val("abort_sig", 64'(signature), 64'(m1));
        @(negedge clk);
        check_val("abort_stay", 64'(busy), 64'(0));
        run_once(1'b1, 1'b0);

        // start together with abort in DONE: no run
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_idle("start_abort");
        @(negedge clk);
        check_val("start_abort_stay", 64'(busy), 64'(0));

        // asynchronous reset between clock edges
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        check_val("async_rst_sig", 64'(signature), 64'(0));
        check_val("async_rst_cnt", 64'(pat_cnt),   64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("rst_quiet_busy", 64'(busy),      64'(0));
            check_val("rst_quiet_sig",  64'(signature), 64'(0));
        end

        for (int n = 0; n < 6; n++) begin
            run_once(1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
